// File: rtl/mcp3208_pkg.sv
// MCP3208 frame constants and controller state encoding.
// Shared by the controller RTL and the behavioral ADC model in the bench.
// Frame: SETUP half-period, then 19 SCLK pulses; data bits on pulses 8..19.
package mcp3208_pkg;

  localparam int N_PULSE    = 19;  // SCLK pulses per conversion frame
  localparam int N_CMD      = 5;   // command bits: start, sgl, D2, D1, D0
  localparam int FIRST_DATA = 8;   // pulse carrying result bit D11
  localparam int N_BITS     = 12;  // result width

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } state_t;

endpackage

// File: rtl/mcp3208_tick.sv
// Half-period pacer: one-cycle tick every HALF clk cycles while not cleared.
// Latency: first tick HALF cycles after clr drops; tick never fires while clr=1.
// No backpressure: free-running counter, clr restarts the period.
module mcp3208_tick #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt;
  logic       at_end;

  assign at_end = (cnt == 8'(HALF - 1));
  assign tick   = at_end && !clr;

  // Count 0..HALF-1 and wrap; clr holds the count at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mcp3208_ctrl.sv
// MCP3208 SPI mode-0 conversion controller: sends {1,sgl,chan}, reads 12 bits.
// Latency: CS low 39*HALF cycles, done one cycle after the last LOW half-period.
// Backpressure: start is ignored while busy; no request queuing.
module mcp3208_ctrl
  import mcp3208_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgl,
  input  logic [2:0]  chan,
  output logic        busy,
  output logic        done,
  output logic [11:0] data,
  output logic        CS,
  output logic        SCLK,
  output logic        DIN,
  input  logic        DOUT
);

  state_t              state;
  state_t              state_nx;
  logic                tick;
  logic                clr;
  logic                accept;
  logic                frame_end;
  logic                sample;
  logic [4:0]          pulse;
  logic [N_CMD-1:0]    cmd;
  logic [N_BITS-1:0]   shreg;
  logic [2:0]          din_sel;

  mcp3208_tick #(.HALF(HALF)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; every transition out of a timed state waits for a tick.
  always_comb begin
    state_nx  = state;
    clr       = 1'b0;
    accept    = 1'b0;
    frame_end = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_nx = HIGH;
      end
      HIGH: begin
        if (tick) state_nx = LOW;
      end
      LOW: begin
        if (tick) begin
          if (pulse == 5'(N_PULSE)) begin
            frame_end = 1'b1;
            state_nx  = HOLD;
          end else begin
            state_nx = HIGH;
            // DOUT is taken on the edge where SCLK rises for a data pulse.
            sample   = (pulse >= 5'(FIRST_DATA - 1));
          end
        end
      end
      HOLD: begin
        if (tick && pulse == 5'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin drive decoded from state and pulse number; DIN moves only on falling edges.
  always_comb begin
    CS      = 1'b1;
    SCLK    = 1'b0;
    DIN     = 1'b0;
    din_sel = 3'd0;
    busy    = (state != IDLE);
    case (state)
      SETUP: begin
        CS  = 1'b0;
        DIN = cmd[N_CMD-1];
      end
      HIGH: begin
        CS   = 1'b0;
        SCLK = 1'b1;
        if (pulse <= 5'(N_CMD)) begin
          din_sel = 3'(5'(N_CMD) - pulse);
          DIN     = cmd[din_sel];
        end
      end
      LOW: begin
        CS = 1'b0;
        if (pulse < 5'(N_CMD)) begin
          din_sel = 3'(5'(N_CMD - 1) - pulse);
          DIN     = cmd[din_sel];
        end
      end
      default: ;
    endcase
  end

  // Pulse number within the frame; in HOLD it counts elapsed half-periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse <= '0;
    end else if (state == IDLE) begin
      pulse <= '0;
    end else if (state == SETUP && tick) begin
      pulse <= 5'd1;
    end else if (state == LOW && tick) begin
      pulse <= frame_end ? 5'd0 : pulse + 5'd1;
    end else if (state == HOLD && tick) begin
      pulse <= pulse + 5'd1;
    end
  end

  // Command capture on accept and MSB-first result shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd   <= '0;
      shreg <= '0;
    end else begin
      if (accept) cmd <= {1'b1, sgl, chan};
      if (sample) shreg <= {shreg[N_BITS-2:0], DOUT};
    end
  end

  // Result publish with a single-cycle done strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      data <= '0;
    end else begin
      done <= frame_end;
      if (frame_end) data <= shreg;
    end
  end

endmodule

// File: tb/tb_mcp3208_ctrl.sv
// Directed bench: two controllers (HALF=4 and HALF=1) each paired with an ADC model.
module tb_mcp3208_ctrl;
  import mcp3208_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_w [2];
  logic        sgl_w   [2];
  logic [2:0]  chan_w  [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [11:0] data_w  [2];
  logic        cs_w    [2];
  logic        sclk_w  [2];
  logic        din_w   [2];
  logic        dout_w  [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mcp3208_ctrl #(.HALF(4)) dut0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .sgl(sgl_w[0]), .chan(chan_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .data(data_w[0]),
    .CS(cs_w[0]), .SCLK(sclk_w[0]), .DIN(din_w[0]), .DOUT(dout_w[0])
  );

  mcp3208_ctrl #(.HALF(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .sgl(sgl_w[1]), .chan(chan_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .data(data_w[1]),
    .CS(cs_w[1]), .SCLK(sclk_w[1]), .DIN(din_w[1]), .DOUT(dout_w[1])
  );

  // ADC model: fixed result per {sgl,chan}.
  function automatic logic [11:0] lookup(input logic [3:0] sc);
    case (sc)
      4'b1010: return 12'h123;
      4'b1111: return 12'hfef;
      4'b1000: return 12'h111;
      4'b1101: return 12'h9ab;
      4'b1100: return 12'h678;
      default: return 12'h555;
    endcase
  endfunction

  logic [4:0]  m_cmd  [2];
  logic [11:0] m_res  [2];
  int          m_n    [2];
  logic        m_cs   [2];
  logic        m_sclk [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cmd[i] = '0; m_res[i] = '0; m_n[i] = 0; m_cs[i] = 1'b1; m_sclk[i] = 1'b0;
      dout_w[i] = 1'b0;
    end
  end

  // MCP3208 model: captures DIN on SCLK rise, shifts DOUT on SCLK fall.
  always @(cs_w[0] or sclk_w[0] or cs_w[1] or sclk_w[1]) begin
    for (int i = 0; i < 2; i++) begin
      int nx;
      if (!cs_w[i] && m_cs[i]) begin
        m_n[i] = 0;
        dout_w[i] = 1'b0;
      end else if (!cs_w[i] && sclk_w[i] && !m_sclk[i]) begin
        m_n[i] = m_n[i] + 1;
        if (m_n[i] <= N_CMD) m_cmd[i] = {m_cmd[i][3:0], din_w[i]};
        if (m_n[i] == N_CMD) m_res[i] = lookup(m_cmd[i][3:0]);
      end else if (!cs_w[i] && !sclk_w[i] && m_sclk[i]) begin
        nx = m_n[i] + 1;
        if (nx >= FIRST_DATA && nx <= N_PULSE) dout_w[i] = m_res[i][N_PULSE - nx];
        else dout_w[i] = 1'b0;
      end
      m_cs[i]   = cs_w[i];
      m_sclk[i] = sclk_w[i];
    end
  end

  // Pin monitors sampled on the inactive edge.
  int   done_cnt [2];
  int   cs_low [2], last_low [2], cs_hi [2], last_gap [2];
  int   rises [2], last_rises [2], hi_run [2], max_hi [2], last_max_hi [2];
  logic p_sclk [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; cs_low[i] = 0; last_low[i] = 0; cs_hi[i] = 0; last_gap[i] = 0;
      rises[i] = 0; last_rises[i] = 0; hi_run[i] = 0; max_hi[i] = 0; last_max_hi[i] = 0;
      p_sclk[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_w[i]) done_cnt[i] = done_cnt[i] + 1;
      if (!cs_w[i]) begin
        if (cs_hi[i] != 0) last_gap[i] = cs_hi[i];
        cs_hi[i]  = 0;
        cs_low[i] = cs_low[i] + 1;
        if (sclk_w[i] && !p_sclk[i]) rises[i] = rises[i] + 1;
        if (sclk_w[i]) begin
          hi_run[i] = hi_run[i] + 1;
          if (hi_run[i] > max_hi[i]) max_hi[i] = hi_run[i];
        end else begin
          hi_run[i] = 0;
        end
      end else begin
        if (cs_low[i] != 0) begin
          last_low[i]    = cs_low[i];
          last_rises[i]  = rises[i];
          last_max_hi[i] = max_hi[i];
        end
        cs_low[i] = 0; rises[i] = 0; max_hi[i] = 0; hi_run[i] = 0;
        cs_hi[i]  = cs_hi[i] + 1;
      end
      p_sclk[i] = sclk_w[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int i, input int d0);
    int k = 0;
    while (done_cnt[i] == d0 && k < 3000) begin
      step();
      k++;
    end
    chk(tag, done_cnt[i] - d0, 1);
  endtask

  task automatic wait_rise(input int i, input int n);
    int k = 0;
    while (rises[i] != n && k < 3000) begin
      step();
      k++;
    end
    chk("rise_reach", rises[i], n);
  endtask

  task automatic run_frame(input string tag, input int i, input logic s, input logic [2:0] c);
    int d0 = done_cnt[i];
    start_w[i] = 1'b1; sgl_w[i] = s; chan_w[i] = c;
    step();
    start_w[i] = 1'b0;
    wait_done(tag, i, d0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 2; i++) begin
      start_w[i] = 1'b0; sgl_w[i] = 1'b0; chan_w[i] = 3'd0;
    end
    rst = 1'b1;
    repeat (3) step();

    // Reset state.
    chk("rst_cs", cs_w[0], 1);
    chk("rst_sclk", sclk_w[0], 0);
    chk("rst_din", din_w[0], 0);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_data", data_w[0], 12'h000);
    chk("rst_cs1", cs_w[1], 1);
    rst = 1'b0;
    repeat (2) step();

    // Single conversion, sgl=1 chan=2.
    run_frame("f1_done", 0, 1'b1, 3'd2);
    chk("f1_data", data_w[0], 12'h123);
    chk("f1_cmd_bits", m_cmd[0], 5'b11010);
    chk("f1_cs_low", last_low[0], 156);
    chk("f1_pulses", last_rises[0], 19);
    chk("f1_sclk_hi", last_max_hi[0], 4);
    chk("f1_busy_hold", busy_w[0], 1);
    repeat (10) step();
    chk("f1_busy_idle", busy_w[0], 0);
    chk("f1_done_once", done_cnt[0], 1);

    // Back-to-back frames with start held.
    d0 = done_cnt[0];
    start_w[0] = 1'b1; sgl_w[0] = 1'b1; chan_w[0] = 3'd7;
    wait_done("b2b_done1", 0, d0);
    chk("b2b_data1", data_w[0], 12'hfef);
    chan_w[0] = 3'd0;
    wait_done("b2b_done2", 0, d0 + 1);
    start_w[0] = 1'b0;
    chk("b2b_data2", data_w[0], 12'h111);
    chk("b2b_gap_ge8", last_gap[0] >= 8, 1);
    repeat (30) step();
    chk("b2b_two_done", done_cnt[0] - d0, 2);

    // Start during a frame and during HOLD is ignored.
    d0 = done_cnt[0];
    start_w[0] = 1'b1; sgl_w[0] = 1'b1; chan_w[0] = 3'd2;
    step();
    start_w[0] = 1'b0;
    wait_rise(0, 10);
    start_w[0] = 1'b1; chan_w[0] = 3'd7;
    step();
    start_w[0] = 1'b0;
    wait_done("ign_done", 0, d0);
    step();
    start_w[0] = 1'b1;
    step();
    start_w[0] = 1'b0;
    repeat (40) step();
    chk("ign_one_done", done_cnt[0] - d0, 1);
    chk("ign_data", data_w[0], 12'h123);
    chk("ign_idle", busy_w[0], 0);

    // Reset mid-frame.
    d0 = done_cnt[0];
    start_w[0] = 1'b1; sgl_w[0] = 1'b1; chan_w[0] = 3'd3;
    step();
    start_w[0] = 1'b0;
    wait_rise(0, 12);
    rst = 1'b1;
    #1;
    chk("mrst_cs", cs_w[0], 1);
    chk("mrst_sclk", sclk_w[0], 0);
    chk("mrst_data", data_w[0], 12'h000);
    repeat (3) step();
    rst = 1'b0;
    repeat (200) step();
    chk("mrst_no_done", done_cnt[0] - d0, 0);
    chk("mrst_idle", busy_w[0], 0);
    run_frame("mrst_next_done", 0, 1'b1, 3'd5);
    chk("mrst_next_data", data_w[0], 12'h9ab);

    // HALF=1 instance.
    run_frame("h1_done", 1, 1'b1, 3'd4);
    chk("h1_data", data_w[1], 12'h678);
    chk("h1_cs_low", last_low[1], 39);
    chk("h1_pulses", last_rises[1], 19);
    chk("h1_sclk_hi", last_max_hi[1], 1);
    repeat (10) step();
    chk("h1_idle", busy_w[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
